// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers the fetched word into IF/ID, honouring reset > flush > stall > normal.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] pc_next;

  assign pc_next = pc_q + 32'd4;

  // id_valid marks IF/ID as holding a real instruction; a bubble (valid=0)
  // carries BUBBLE so the decoder does nothing even if it ignores id_valid.
  always_comb begin
    pc_d         = pc_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      id_inst_d    = BUBBLE;
      id_pc_d      = 32'd0;
      id_pc4_d     = 32'd0;
      id_valid_d   = 1'b0;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (!stall) begin
      pc_d         = pc_next;
      id_inst_d    = irom_inst;
      id_pc_d      = pc_q;
      id_pc4_d     = pc_next;
      id_valid_d   = 1'b1;
      fetch_cnt_d  = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q         <= RESET_PC;
      id_inst_q    <= BUBBLE;
      id_pc_q      <= 32'd0;
      id_pc4_q     <= 32'd0;
      id_valid_q   <= 1'b0;
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign irom_addr  = pc_q;
  assign id_inst    = id_inst_q;
  assign id_pc      = id_pc_q;
  assign id_pc4     = id_pc4_q;
  assign id_valid   = id_valid_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small ROM model feeds the stage and each step
// checks the PC, IF/ID register and counters against hand-computed values.
module tb_if_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst, stall, flush;
  logic [31:0] redirect_pc;
  logic [31:0] irom_addr, irom_inst;
  logic [31:0] id_inst, id_pc, id_pc4, fetch_cnt, bubble_cnt;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .BUBBLE(32'h0000_0000)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .irom_addr(irom_addr), .irom_inst(irom_inst),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0000_0293;
    else if (a == 32'h4) return 32'h0010_0313;
    else                 return 32'hC300_0000 ^ a;
  endfunction

  assign irom_inst = rom_word(irom_addr);

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    cpu_rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    step(); step();
    check("rst_addr", irom_addr, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_fcnt", fetch_cnt, 32'd0);
    check("rst_bcnt", bubble_cnt, 32'd0);

    cpu_rst = 1'b0;
    check("c0_addr", irom_addr, 32'h0);
    step();
    check("e1_inst", id_inst, 32'h0000_0293);
    check("e1_pc", id_pc, 32'h0);
    check("e1_pc4", id_pc4, 32'h4);
    check("e1_valid", {31'd0, id_valid}, 32'd1);
    check("e1_addr", irom_addr, 32'h4);
    step();
    check("e2_inst", id_inst, 32'h0010_0313);
    check("e2_fcnt", fetch_cnt, 32'd2);
    check("e2_addr", irom_addr, 32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", irom_addr, 32'h8);
      check("stall_inst", id_inst, 32'h0010_0313);
      check("stall_pc", id_pc, 32'h4);
      check("stall_fcnt", fetch_cnt, 32'd2);
    end
    stall = 1'b0;
    step();
    check("unstall_inst", id_inst, 32'hC300_0008);
    check("unstall_pc", id_pc, 32'h8);
    check("unstall_fcnt", fetch_cnt, 32'd3);
    check("unstall_addr", irom_addr, 32'hC);

    flush = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    check("fl_valid", {31'd0, id_valid}, 32'd0);
    check("fl_inst", id_inst, 32'h0);
    check("fl_pc", id_pc, 32'h0);
    check("fl_pc4", id_pc4, 32'h0);
    check("fl_addr", irom_addr, 32'h40);
    check("fl_bcnt", bubble_cnt, 32'd1);
    check("fl_fcnt", fetch_cnt, 32'd3);
    flush = 1'b0;
    step();
    check("tgt_pc", id_pc, 32'h40);
    check("tgt_inst", id_inst, 32'hC300_0040);
    check("tgt_valid", {31'd0, id_valid}, 32'd1);
    check("tgt_fcnt", fetch_cnt, 32'd4);

    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    check("fs_addr", irom_addr, 32'h100);
    check("fs_valid", {31'd0, id_valid}, 32'd0);
    check("fs_inst", id_inst, 32'h0);
    check("fs_bcnt", bubble_cnt, 32'd2);
    check("fs_fcnt", fetch_cnt, 32'd4);

    stall = 1'b0; redirect_pc = 32'h0000_0200;
    step();
    check("b2b_addr", irom_addr, 32'h200);
    check("b2b_bcnt", bubble_cnt, 32'd3);
    flush = 1'b0;
    step();
    check("b2b_pc", id_pc, 32'h200);
    check("b2b_fcnt", fetch_cnt, 32'd5);

    flush = 1'b1; redirect_pc = 32'h0000_001C;
    step();
    flush = 1'b0;
    step();
    check("pre_addr", irom_addr, 32'h20);
    check("pre_fcnt", fetch_cnt, 32'd6);
    check("pre_bcnt", bubble_cnt, 32'd4);
    stall = 1'b1;
    step();
    check("pre_stall_addr", irom_addr, 32'h20);
    cpu_rst = 1'b1;
    step();
    check("mrst_addr", irom_addr, 32'h0);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_inst", id_inst, 32'h0);
    check("mrst_fcnt", fetch_cnt, 32'd0);
    check("mrst_bcnt", bubble_cnt, 32'd0);

    cpu_rst = 1'b0; stall = 1'b0;
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wr_addr", irom_addr, 32'hFFFF_FFFC);
    check("wr_bcnt", bubble_cnt, 32'd1);
    flush = 1'b0;
    step();
    check("wr_idpc", id_pc, 32'hFFFF_FFFC);
    check("wr_pc4", id_pc4, 32'h0);
    check("wr_addr0", irom_addr, 32'h0);
    check("wr_inst", id_inst, 32'h3CFF_FFFC);
    check("wr_fcnt", fetch_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
